dot_accumulator: RTL and testbench
==================================

// Module: dot_accumulator
// PURPOSE
//  Downstream consumer of the two-lane multiply-add stage: takes each registered
//  partial sum C (A1*B1 + A2*B2) and accumulates beats into one dot-product result.
//  Packet ends on in_last or after MAX_TERMS beats; result held with valid/ready.
//  Overflow is flagged per packet.
// PARAMETERS
//  IN_W      32  width of incoming partial sum (unsigned)
//  ACC_W     40  accumulator / result width (must be >= IN_W)
//  MAX_TERMS 16  beats per packet before forced close (>= 1)
//  CNT_W     5   beat-counter width; must hold MAX_TERMS
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      in_data/in_last valid this cycle
//  in_data    in   IN_W   partial sum from multiply-add stage, unsigned
//  in_last    in   1      beat is final term of packet
//  in_ready   out  1      block accepts a beat this cycle
//  out_valid  out  1      out_data/out_terms/out_ovf hold a finished packet
//  out_ready  in   1      consumer takes result this cycle
//  out_data   out  ACC_W  accumulated sum
//  out_terms  out  CNT_W  number of beats summed (1..MAX_TERMS)
//  out_ovf    out  1      sticky: sum exceeded 2^ACC_W-1 during packet
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All state updates on posedge clk.
//  - Reset: state=ACC, acc=0, terms=0, ovf=0 -> out_data=0, out_terms=0, out_ovf=0,
//    out_valid=0. in_ready=0 in any cycle reset is high. Reset mid-packet discards partial sum.
//  - States: ACC (collecting), DONE (holding result).
//  - in_ready = (state==ACC) && !reset; combinational, never depends on in_valid.
//  - Beat accepted iff in_valid && in_ready. Without acceptance nothing changes.
//  - On accept in ACC: acc <= acc + {0,in_data} (ACC_W+1-bit add); terms <= terms+1;
//    ovf <= ovf | carry. Close if in_last || terms==MAX_TERMS-1 -> state DONE.
//  - Latency: result valid the cycle after the closing beat is accepted (1 clk).
//  - DONE: out_valid=1; out_data=acc, out_terms=terms, out_ovf=ovf stable until handshake.
//    in_ready=0 (no overlap of packets). out_valid never drops without out_ready.
//  - out_valid && out_ready: next cycle acc=0, terms=0, ovf=0, state=ACC, out_valid=0.
//    Next packet's first beat accepted no earlier than that cycle (1 bubble per packet).
//  - out_ready ignored when out_valid=0. in_last ignored when in_valid=0.
//  - Wrap rule (default): acc keeps low ACC_W bits of sum; carry only sets ovf.
//  - MAX_TERMS=1: every accepted beat closes the packet.
//  - Reset high together with a handshake: reset wins.
// CONFIGURATION
//  DOT_ACC_SAT_EN defined: on carry, acc <= {ACC_W{1'b1}} and stays saturated for rest
//    of packet (further adds keep all-ones); ovf still set.
//  DOT_ACC_SAT_EN undefined: modulo-2^ACC_W wrap as above. Ports identical in both.
// TESTING
//  1 reset held 2 clk -> out_valid=0, out_data=0, out_terms=0, out_ovf=0, in_ready=0;
//    after release in_ready=1.
//  2 beats 10,20,30(last), out_ready=1 -> 1 clk later out_valid=1, out_data=60,
//    out_terms=3, out_ovf=0; next cycle out_valid=0, in_ready=1.
//  3 16 beats of 1, in_last never set -> forced close: out_data=16, out_terms=16;
//    17th beat presented stalls (in_ready=0) until result taken.
//  4 out_ready=0 for 5 clk while in_valid=1 -> out_* stable, in_ready=0, no beat lost;
//    out_ready=1 -> pending beat accepted into new packet.
//  5 ACC_W=32: beats 32'hFFFF_FFFF, 2(last) -> out_ovf=1; wrap out_data=1;
//    with DOT_ACC_SAT_EN out_data=32'hFFFF_FFFF.
//  6 two beats accepted, reset pulsed 1 clk, then beat 7(last) -> out_data=7,
//    out_terms=1.

Source files
------------

// File: rtl/dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dot_accumulator
// Purpose  : Accumulates the registered partial sums produced by the two-lane
//            multiply-add stage into one dot-product result per packet.
//            A packet closes on in_last or after MAX_TERMS accepted beats.
//            The finished result is held on a valid/ready output until it is
//            taken. Only then does the block collect the next packet.
//            Overflow is flagged per packet.
// Build    : DOT_ACC_SAT_EN defined   -> saturate the accumulator to all-ones
//                                        on the first carry; it stays
//                                        saturated for the rest of the packet.
//            DOT_ACC_SAT_EN undefined -> modulo-2^ACC_W wrap; the carry only
//                                        sets the overflow flag.
//            The port list is the same in both builds.
// Ports    : clk        in   1      rising-edge clock
//            reset      in   1      synchronous, active-high reset
//            in_valid   in   1      in_data/in_last valid this cycle
//            in_data    in   IN_W   unsigned partial sum
//            in_last    in   1      beat is the final term of its packet
//            in_ready   out  1      a beat is accepted this cycle
//            out_valid  out  1      out_data/out_terms/out_ovf hold a result
//            out_ready  in   1      consumer takes the result this cycle
//            out_data   out  ACC_W  accumulated sum
//            out_terms  out  CNT_W  number of beats summed (1..MAX_TERMS)
//            out_ovf    out  1      sum exceeded 2^ACC_W-1 during the packet
// Revision : 1.0  initial release
// ============================================================================
module dot_accumulator #(
  parameter int IN_W      = 32,
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_terms,
  output logic             out_ovf
);

  // Beat count, before the current beat is added, at which the packet must
  // be force-closed.
  localparam logic [CNT_W-1:0] c_LAST_TERM = CNT_W'(MAX_TERMS - 1);

  typedef enum logic [0:0] {
    S_ACC  = 1'b0,  // collecting beats
    S_DONE = 1'b1   // holding a finished result
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   terms_q, terms_d;
  logic               ovf_q,   ovf_d;

  logic               w_accept;
  logic               w_close;
  logic [ACC_W:0]     w_sum;

  // in_ready depends only on state and reset. It never depends on in_valid,
  // so an upstream stage may wait on it without forming a combinational loop.
  assign in_ready = (state_q == S_ACC) && !reset;
  assign w_accept = in_valid && in_ready;

  // The add is one bit wider than the accumulator, so the carry out of the
  // top bit is visible.
  assign w_sum    = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign w_close  = in_last || (terms_q == c_LAST_TERM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    terms_d = terms_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_ACC: begin
        if (w_accept) begin
          terms_d = terms_q + CNT_W'(1);
          ovf_d   = ovf_q | w_sum[ACC_W];
`ifdef DOT_ACC_SAT_EN
          // After the first carry the sum stays pinned at all-ones until
          // the packet is handed off.
          if (ovf_q || w_sum[ACC_W]) begin
            acc_d = {ACC_W{1'b1}};
          end else begin
            acc_d = w_sum[ACC_W-1:0];
          end
`else
          acc_d   = w_sum[ACC_W-1:0];
`endif
          if (w_close) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // The result registers double as the output holding registers, so
        // they are cleared only once the consumer has taken the result.
        if (out_ready) begin
          state_d = S_ACC;
          acc_d   = '0;
          terms_d = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      terms_q <= terms_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign out_terms = terms_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_accumulator
// Purpose  : Self-checking bench for dot_accumulator. The design is built with
//            ACC_W = IN_W = 32 so that one carry out of the accumulator can be
//            reached. The expected overflow result follows DOT_ACC_SAT_EN.
//            When the bench drives a closing beat, it pushes the expected
//            packet results onto a queue. A monitor pops and compares one
//            entry on every output handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_dot_accumulator;

  localparam int IN_W      = 32;
  localparam int ACC_W     = 32;
  localparam int MAX_TERMS = 16;
  localparam int CNT_W     = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_terms;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] terms;
    logic             ovf;
  } result_t;

  result_t sb_q[$];

  // Reference model of the packet that is currently being collected.
  logic [ACC_W-1:0] m_acc;
  int               m_terms;
  logic             m_ovf;

  dot_accumulator #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .MAX_TERMS (MAX_TERMS),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_terms (out_terms),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc   = '0;
    m_terms = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
    logic [ACC_W:0] s;
    result_t        r;
    s = {1'b0, m_acc} + {1'b0, d};
`ifdef DOT_ACC_SAT_EN
    if (m_ovf || s[ACC_W]) m_acc = {ACC_W{1'b1}};
    else                   m_acc = s[ACC_W-1:0];
`else
    m_acc = s[ACC_W-1:0];
`endif
    m_ovf   = m_ovf | s[ACC_W];
    m_terms = m_terms + 1;
    if (l || m_terms == MAX_TERMS) begin
      r.data  = m_acc;
      r.terms = CNT_W'(m_terms);
      r.ovf   = m_ovf;
      sb_q.push_back(r);
      model_clear();
    end
  endtask

  // Present a beat and hold it until it is accepted. On return it is 1 ns
  // after the accepting edge, and in_valid is low.
  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(n), 64'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_accept(d, l);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Hold a result for several cycles while a beat waits, then release it.
  task automatic stall_and_release(input int cycles, input logic [ACC_W-1:0] d,
                                   input logic [CNT_W-1:0] t);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data", 64'(out_data), 64'(d));
      chk("stall_out_terms", 64'(out_terms), 64'(t));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  // Scoreboard monitor: one comparison set per output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        result_t r;
        r = sb_q.pop_front();
        chk("sb_data", 64'(out_data), 64'(r.data));
        chk("sb_terms", 64'(out_terms), 64'(r.terms));
        chk("sb_ovf", 64'(out_ovf), 64'(r.ovf));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();

    // Reset held for two clocks.
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_terms", 64'(out_terms), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Three beats with a one-clock result latency.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b1);
    @(negedge clk);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'd60);
    @(negedge clk);
    chk("after_hs_out_valid", 64'(out_valid), 64'd0);
    chk("after_hs_in_ready", 64'(in_ready), 64'd1);

    // Forced close after MAX_TERMS beats. The 17th beat stalls until the
    // result is taken.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) send(32'd1, 1'b0);
    fork
      send(32'd5, 1'b1);
      stall_and_release(3, 32'd16, 5'd16);
    join

    // Hold the result for five clocks while the next beat waits; no beat
    // may be lost.
    out_ready = 1'b0;
    fork
      send(32'd9, 1'b1);
      stall_and_release(5, 32'd5, 5'd1);
    join

    // Carry out of the 32-bit accumulator.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd2, 1'b1);

    // A reset in the middle of a packet discards the partial sum.
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    send(32'd7, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: stop if the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
